// File: rtl/simplecore_defs.sv
// Shared SimpleCore definitions: instruction/condition codes, datapath widths
// and the fetch-stage constants used across the pipeline.
package simplecore_defs;

   localparam int PC_W   = 16;
   localparam int INST_W = 16;

   localparam logic [INST_W-1:0] FETCH_BUBBLE = 16'h0000;

   typedef enum logic [3:0] {
      INST_NOP  = 4'h0,
      INST_ADD  = 4'h1,
      INST_SUB  = 4'h2,
      INST_AND  = 4'h3,
      INST_OR   = 4'h4,
      INST_LDI  = 4'h5,
      INST_LD   = 4'h6,
      INST_ST   = 4'h7,
      INST_BR   = 4'h8,
      INST_JMP  = 4'h9,
      INST_HALT = 4'hF
   } instOp_t;

   typedef enum logic [2:0] {
      COND_AL = 3'd0,
      COND_EQ = 3'd1,
      COND_NE = 3'd2,
      COND_LT = 3'd3,
      COND_GE = 3'd4
   } cond_t;

   // IDLE has no request on the bus; REQ holds imemReq/imemAddr until acked.
   typedef enum logic {
      FETCH_IDLE = 1'b0,
      FETCH_REQ  = 1'b1
   } fetchState_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {address, instruction} pairs between memory and decode.
// Depth is a power of two so the pointers wrap naturally.
module fetch_queue
   import simplecore_defs::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                           clk,
   input  logic                           nreset,
   input  logic                           clear,
   input  logic                           push,
   input  logic                           pop,
   input  logic [PC_W-1:0]                pushAddr,
   input  logic [INST_W-1:0]              pushInst,
   output logic [$clog2(QDEPTH+1)-1:0]    count,
   output logic [PC_W-1:0]                headAddr,
   output logic [INST_W-1:0]              headInst
);

   localparam int PTR_W = $clog2(QDEPTH);

   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W-1:0]  wrPtr;
   logic [PC_W-1:0]   addrMem [QDEPTH];
   logic [INST_W-1:0] instMem [QDEPTH];

   // Storage needs no reset; count alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         addrMem[wrPtr] <= pushAddr;
         instMem[wrPtr] <= pushInst;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset || clear) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign headAddr = addrMem[rdPtr];
   assign headInst = instMem[rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// SimpleCore fetch stage: single-outstanding instruction memory requests,
// a small prefetch queue, and stall / flush-with-redirect / halt handling.
module fetch_unit
   import simplecore_defs::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter int              QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              stall,
   input  logic              flush,
   input  logic [PC_W-1:0]   flushPc,
   input  logic              halt,
   output logic              imemReq,
   output logic [PC_W-1:0]   imemAddr,
   input  logic              imemAck,
   input  logic [INST_W-1:0] imemData,
   output logic [INST_W-1:0] fInst,
   output logic              fValid,
   output logic [PC_W-1:0]   fPc
);

   localparam int               CNT_W   = $clog2(QDEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

   fetchState_t       state;
   fetchState_t       stateNext;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   pcNext;
   logic [PC_W-1:0]   reqAddr;
   logic [PC_W-1:0]   reqAddrNext;
   logic              discard;
   logic              discardNext;
   logic              accepted;
   logic              pushEn;
   logic              popEn;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  countAfter;
   logic [PC_W-1:0]   headAddr;
   logic [INST_W-1:0] headInst;

   assign accepted = (state == FETCH_REQ) && imemAck;
   assign pushEn   = accepted && !discard && !flush;
   assign fValid   = (count != '0);
   assign popEn    = fValid && !stall && !flush;

   // Queue occupancy after this cycle's push/pop/clear, used to decide
   // whether a follow-on request may be issued straight after an ack.
   always_comb begin
      countAfter = count;
      if (flush)                countAfter = '0;
      else if (pushEn && !popEn) countAfter = count + 1'b1;
      else if (!pushEn && popEn) countAfter = count - 1'b1;
   end

   always_comb begin
      stateNext   = state;
      pcNext      = pc;
      reqAddrNext = reqAddr;
      discardNext = discard;
      case (state)
         FETCH_IDLE: begin
            if (flush) begin
               pcNext      = flushPc;
               reqAddrNext = flushPc;
               stateNext   = halt ? FETCH_IDLE : FETCH_REQ;
            end else begin
               reqAddrNext = pc;
               if (!halt && (count < DEPTH_C)) stateNext = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (flush) begin
               // An un-acked request now returns stale data; remember to drop it.
               pcNext = flushPc;
               if (accepted) begin
                  discardNext = 1'b0;
                  reqAddrNext = flushPc;
                  stateNext   = halt ? FETCH_IDLE : FETCH_REQ;
               end else begin
                  discardNext = 1'b1;
               end
            end else if (accepted) begin
               if (discard) discardNext = 1'b0;
               else         pcNext      = reqAddr + 1'b1;
               reqAddrNext = pcNext;
               stateNext   = (!halt && (countAfter < DEPTH_C)) ? FETCH_REQ : FETCH_IDLE;
            end
         end
         default: stateNext = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state   <= FETCH_IDLE;
         pc      <= RESET_PC;
         reqAddr <= RESET_PC;
         discard <= 1'b0;
      end else begin
         state   <= stateNext;
         pc      <= pcNext;
         reqAddr <= reqAddrNext;
         discard <= discardNext;
      end
   end

   fetch_queue #(
      .QDEPTH(QDEPTH)
   ) queue (
      .clk      (clk),
      .nreset   (nreset),
      .clear    (flush),
      .push     (pushEn),
      .pop      (popEn),
      .pushAddr (reqAddr),
      .pushInst (imemData),
      .count    (count),
      .headAddr (headAddr),
      .headInst (headInst)
   );

   assign imemReq  = (state == FETCH_REQ);
   assign imemAddr = reqAddr;
   assign fInst    = fValid ? headInst : FETCH_BUBBLE;
   assign fPc      = fValid ? headAddr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-level model of the fetch stream.
module tb_fetch_unit;
   import simplecore_defs::*;

   localparam int          QD  = 2;
   localparam logic [15:0] RPC = 16'h0010;

   logic        clk = 1'b0;
   logic        nreset, stall, flush, halt, imemReq, imemAck, fValid;
   logic [15:0] flushPc, imemAddr, imemData, fInst, fPc;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } entry_t;

   entry_t      mq[$];
   logic [15:0] nextFetch, reqAddrM;
   bit          stale, reqPendingPrev, prevHalt;
   int          latSel, curLat, waitCnt, pops, haltCnt;

   fetch_unit #(
      .RESET_PC(RPC),
      .QDEPTH  (QD)
   ) dut (
      .clk     (clk),
      .nreset  (nreset),
      .stall   (stall),
      .flush   (flush),
      .flushPc (flushPc),
      .halt    (halt),
      .imemReq (imemReq),
      .imemAddr(imemAddr),
      .imemAck (imemAck),
      .imemData(imemData),
      .fInst   (fInst),
      .fValid  (fValid),
      .fPc     (fPc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model; called at the falling edge.
   task automatic checkOutput();
      checkBit("fValid", fValid, mq.size() != 0);
      if (mq.size() != 0) begin
         checkVal("fPc", fPc, mq[0].a);
         checkVal("fInst", fInst, mq[0].d);
      end else begin
         checkVal("fPcEmpty", fPc, 16'h0000);
         checkVal("fInstBubble", fInst, FETCH_BUBBLE);
      end
      if (reqPendingPrev) begin
         checkBit("reqHeld", imemReq, 1'b1);
         checkVal("addrHeld", imemAddr, reqAddrM);
      end else if (prevHalt) begin
         checkBit("reqDuringHalt", imemReq, 1'b0);
      end else if (imemReq) begin
         reqAddrM = nextFetch;
         checkVal("reqAddr", imemAddr, reqAddrM);
      end
   endtask

   // One clock of stimulus: memory response, pipeline controls, model update.
   task automatic applyStimulus(input logic st, input logic fl, input logic [15:0] fpc, input logic hl);
      bit     ackNow;
      entry_t e;
      ackNow = 1'b0;
      if (imemReq) begin
         if (!reqPendingPrev) begin
            waitCnt = 0;
            curLat  = (latSel < 0) ? int'($urandom_range(0, 3)) : latSel;
         end else begin
            waitCnt++;
         end
         ackNow = (waitCnt >= curLat);
      end
      imemAck  = ackNow;
      imemData = ackNow ? memWord(imemAddr) : 16'($urandom);
      stall    = st;
      flush    = fl;
      flushPc  = fpc;
      halt     = hl;
      if (fl) begin
         mq.delete();
         nextFetch = fpc;
         if (imemReq && !ackNow) stale = 1'b1;
         else if (ackNow)        stale = 1'b0;
      end else begin
         if (mq.size() != 0 && !st) begin
            void'(mq.pop_front());
            pops++;
         end
         if (ackNow) begin
            if (stale) begin
               stale = 1'b0;
            end else begin
               e.a = reqAddrM;
               e.d = memWord(reqAddrM);
               mq.push_back(e);
               nextFetch = reqAddrM + 16'd1;
            end
         end
      end
      reqPendingPrev = imemReq && !ackNow;
      prevHalt       = hl;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset(input int n);
      nreset   = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;
      halt     = 1'b0;
      imemAck  = 1'b0;
      imemData = 16'h0000;
      flushPc  = 16'h0000;
      repeat (n) @(negedge clk);
      checkBit("rstReq", imemReq, 1'b0);
      checkVal("rstAddr", imemAddr, 16'h0010);
      checkBit("rstValid", fValid, 1'b0);
      checkVal("rstInst", fInst, 16'h0000);
      checkVal("rstPc", fPc, 16'h0000);
      nreset = 1'b1;
      mq.delete();
      nextFetch      = RPC;
      reqAddrM       = RPC;
      stale          = 1'b0;
      reqPendingPrev = 1'b0;
      prevHalt       = 1'b0;
      @(negedge clk);
      checkOutput();
   endtask

   task automatic waitNewReq(input string name, input int limit);
      int n = 0;
      while (!(imemReq && !reqPendingPrev) && n < limit) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
         n++;
      end
      checkBit(name, imemReq && !reqPendingPrev, 1'b1);
   endtask

   task automatic waitValid(input string name, input int limit);
      int n = 0;
      while (!fValid && n < limit) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
         n++;
      end
      checkBit(name, fValid, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      pops    = 0;
      latSel  = 0;
      curLat  = 0;
      waitCnt = 0;
      haltCnt = 0;
      doReset(3);

      // Zero-wait streaming from RESET_PC: request first, valid one cycle later.
      checkBit("firstReq", imemReq, 1'b1);
      checkVal("firstAddr", imemAddr, 16'h0010);
      checkBit("notYetValid", fValid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkBit("validAt2", fValid, 1'b1);
      checkVal("firstPc", fPc, 16'h0010);
      checkVal("firstInst", fInst, 16'h4A3C);
      checkVal("secondAddr", imemAddr, 16'h0011);
      repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkVal("streamPc", fPc, 16'h0014);

      // Stall fills the queue and parks the request.
      repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkVal("stallHeadPc", fPc, 16'h0014);
      checkBit("stallNoReq", imemReq, 1'b0);
      checkBit("stallValid", fValid, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkVal("drainPc", fPc, 16'h0015);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkBit("drainEmpty", fValid, 1'b0);
      checkVal("refillAddr", imemAddr, 16'h0016);

      // Flush during a 3-wait request: old address held, stale data dropped.
      latSel = 3;
      waitNewReq("slowReq", 10);
      checkVal("slowReqAddr", imemAddr, 16'h0016);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
      checkBit("flushReqHeld", imemReq, 1'b1);
      checkVal("flushAddrHeld", imemAddr, 16'h0016);
      checkBit("flushInvalid", fValid, 1'b0);
      waitNewReq("postFlushReq", 10);
      checkVal("redirectAddr", imemAddr, 16'h0100);
      waitValid("postFlushValid", 10);
      checkVal("redirectPc", fPc, 16'h0100);

      // Flush coincident with an ack: no discard, redirect issues immediately.
      latSel = 0;
      repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0020, 1'b0);
      checkBit("req20", imemReq, 1'b1);
      checkVal("addr20", imemAddr, 16'h0020);
      applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
      checkBit("ackFlushReq", imemReq, 1'b1);
      checkVal("ackFlushAddr", imemAddr, 16'h0200);
      checkBit("ackFlushInvalid", fValid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkVal("ackFlushPc", fPc, 16'h0200);
      checkVal("ackFlushInst", fInst, 16'h5A3E);

      // PC wraps from 0xFFFF to 0x0000.
      applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0);
      checkVal("wrapFirst", imemAddr, 16'hFFFF);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkVal("wrapNext", imemAddr, 16'h0000);

      // Halt lets the outstanding request finish, then fetch stops and drains.
      latSel = 2;
      waitNewReq("haltReq", 10);
      repeat (8) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
      checkBit("haltNoReq", imemReq, 1'b0);
      checkBit("haltDrained", fValid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkBit("resumeReq", imemReq, 1'b1);
      checkVal("resumeAddr", imemAddr, 16'h0001);

      // Randomized traffic with a reset dropped into the middle.
      latSel = -1;
      pops   = 0;
      for (int i = 0; i < 3000; i++) begin
         logic st, fl, hl;
         if (i == 1500) doReset(2);
         st = ($urandom_range(0, 9) < 3);
         fl = ($urandom_range(0, 99) < 3);
         if (haltCnt > 0) begin
            hl = 1'b1;
            haltCnt--;
         end else begin
            hl = 1'b0;
            if ($urandom_range(0, 99) < 2) haltCnt = int'($urandom_range(1, 8));
         end
         applyStimulus(st, fl, 16'($urandom), hl);
      end
      checkBit("progress", pops > 300, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for SimpleCore; producer of the 16-bit fInst stream consumed by the decode stage.
- Holds the word-addressed PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch queue and honours pipeline stall, flush-with-redirect and halt.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
QDEPTH, 2, prefetch queue depth in instructions (power of two, >=2)

Ports:
clk  input  1  main clock
nreset  input  1  reset
stall  input  1  downstream not accepting; hold queue head
flush  input  1  pipeline flush; discard queued/in-flight instructions
flushPc  input  16  redirect target, sampled when flush=1
halt  input  1  stop issuing new fetches (driven from exitFlag)
imemReq  output  1  instruction memory request
imemAddr  output  16  word address of request
imemAck  input  1  request accepted, imemData valid this cycle
imemData  input  16  instruction word
fInst  output  16  instruction to decode
fValid  output  1  fInst holds a real instruction
fPc  output  16  address of fInst

Behaviour:
- Reset is nreset, synchronous, active-low, on clk.
- Reset values: pc=RESET_PC; queue empty; discard=0; imemReq=0; imemAddr=RESET_PC; fValid=0; fInst=FETCH_BUBBLE (16'h0000); fPc=16'h0000.
- Reset mid-transaction abandons the request; the memory must tolerate a dropped req.
- State is two-state: IDLE (imemReq=0) and REQ (imemReq=1).
- IDLE->REQ when !halt && count < QDEPTH, evaluated on registered count. The request address is the registered pc.
- In REQ, imemReq and imemAddr are held stable until imemAck=1. A request is never withdrawn except by reset.
- On ack: if discard=0, push {imemAddr, imemData} and set pc = imemAddr+1, wrapping mod 2^16 (16'hFFFF -> 16'h0000). If discard=1, drop the data and clear discard. Next state is REQ again if the IDLE->REQ condition still holds (evaluated with post-update count), else IDLE.
- Back-to-back acks give one instruction per cycle.
- Output side is combinational from the queue head:
  - fValid = (count != 0)
  - fInst = head instruction, or FETCH_BUBBLE when empty
  - fPc = head address, or 16'h0000 when empty
- Pop when fValid && !stall && !flush.
- Push and pop in the same cycle is legal; count is unchanged. Overflow cannot occur because a push only happens on ack and requests are gated on count < QDEPTH.
- Flush (highest priority; overrides stall, ack push and halt for that cycle):
  - Queue cleared; pc <= flushPc.
  - If a request is outstanding and not acked this cycle, discard <= 1 (stale response is dropped). If it is acked in the flush cycle, the data is dropped directly and discard stays 0.
  - fValid=0 the cycle after flush.
  - The first request to flushPc is raised the cycle after flush when no stale request is pending; otherwise it follows the stale ack.
- Repeated flush while discard=1: pc is updated to the newest flushPc; discard stays 1; only one stale response is dropped.
- Halt: no new requests while halt=1. An outstanding request completes normally; queued instructions continue to drain. Deassertion resumes fetch at pc.
- Latency: with zero-wait memory (ack in the request cycle), fValid rises 2 cycles after nreset deasserts: req in cycle 1, push at end of cycle 1, valid in cycle 2.

Decomposition:
- Shared package simplecore_defs: existing INST_* and COND_* codes, plus FETCH_BUBBLE (16'h0000), PC_W (16), INST_W (16).
- One sub-module, fetch_queue: synchronous FIFO of {addr,inst} with parameter QDEPTH, push/pop/clear, count, head outputs, and wrap-around read/write pointers.

Test Plan:
- Zero-wait memory, RESET_PC=16'h0010, no stall → imemAddr sequence 0x0010, 0x0011, 0x0012… one per cycle; fPc/fInst match memory in order; first fValid 2 cycles after reset release.
- stall=1 for 5 cycles with memory acking immediately → queue fills to 2; imemReq drops; fInst/fPc held at the same head value. On release, the held instructions appear in order with no loss or duplication.
- Memory acks after 3 wait cycles; flush with flushPc=16'h0100 asserted in wait cycle 1 → imemAddr held at old address until ack; stale data never appears on fInst. Next request address is 0x0100; first fPc after flush is 0x0100.
- Flush in the same cycle as an ack at address 0x0020 → that data is dropped; discard not set; next request at flushPc immediately.
- pc=16'hFFFF fetch → next imemAddr=16'h0000.
- halt=1 while a request is outstanding → that ack completes; no further imemReq; queue drains to fValid=0. Deassert halt → fetch resumes at the next sequential address.
